// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the configuration-chain memory.
//   state_t    : framing state of the chain (idle, loading, full, overrun)
//   cnt_width  : width of the shift counter; it must hold 0..NUM_BITS+1
package cfg_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_FULL    = 2'd2,
    ST_OVERRUN = 2'd3
  } state_t;

  function automatic int cnt_width(input int num_bits);
    return $clog2(num_bits + 2);
  endfunction

endpackage

// File: rtl/cfg_shift_chain.sv
// Bare serial configuration shift register.
//   clk      : programming clock, rising edge
//   rst      : synchronous active-high reset, clears the register
//   head     : serial data in, enters at sr[0]
//   shift_en : shift one position this cycle
//   tail     : serial data out, sr[NUM_BITS-1]
//   sr       : parallel view of the register
module cfg_shift_chain #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                head,
  input  logic                shift_en,
  output logic                tail,
  output logic [NUM_BITS-1:0] sr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (shift_en) begin
      sr[0] <= head;
      for (int i = 1; i < NUM_BITS; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // Tail comes straight from a flop, so chained instances see a clean registered bit.
  assign tail = sr[NUM_BITS-1];

endmodule

// File: rtl/cfg_chain_mem_shadowed.sv
// Configuration-chain memory with frame checking and an optional shadow register.
//   prog_clk   : programming clock, rising edge
//   prog_reset : synchronous active-high reset
//   ccff_head  : serial config data in
//   shift_en   : shift one bit this cycle
//   commit     : one-cycle request to transfer the shift register to mem_out
//   ccff_tail  : serial data out (last bit of the shift register)
//   mem_out    : active configuration bits
//   mem_outb   : bitwise complement of mem_out
//   commit_ok  : one-cycle pulse, the previous-cycle commit was accepted
//   cfg_err    : sticky, a commit was rejected because the frame length was wrong
//   cfg_valid  : sticky, at least one commit was accepted since reset
module cfg_chain_mem_shadowed
  import cfg_chain_pkg::*;
#(
  parameter int NUM_BITS = 4,
  parameter bit SHADOW   = 1'b1
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                ccff_head,
  input  logic                shift_en,
  input  logic                commit,
  output logic                ccff_tail,
  output logic [NUM_BITS-1:0] mem_out,
  output logic [NUM_BITS-1:0] mem_outb,
  output logic                commit_ok,
  output logic                cfg_err,
  output logic                cfg_valid
);

  localparam int CW = cnt_width(NUM_BITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_BITS + 1);

  logic [NUM_BITS-1:0] sr;
  logic [CW-1:0]       cnt, cnt_nxt;
  state_t              state, state_nxt;
  logic                accept;

  cfg_shift_chain #(
    .NUM_BITS (NUM_BITS)
  ) u_chain (
    .clk      (prog_clk),
    .rst      (prog_reset),
    .head     (ccff_head),
    .shift_en (shift_en),
    .tail     (ccff_tail),
    .sr       (sr)
  );

  // The state is a pure function of the count; registering both keeps them in step.
  function automatic state_t state_of(input logic [CW-1:0] c);
    if (c == '0)            return ST_IDLE;
    else if (c < CNT_FULL)  return ST_LOAD;
    else if (c == CNT_FULL) return ST_FULL;
    else                    return ST_OVERRUN;
  endfunction

  always_comb begin
    cnt_nxt = cnt;
    accept  = 1'b0;
    if (commit) begin
      // Commit judges the frame already in sr; a bit shifted in the same cycle
      // is the first bit of the next frame.
      accept  = (state == ST_FULL);
      cnt_nxt = shift_en ? CW'(1) : '0;
    end else if (shift_en && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + 1'b1;
    end
    state_nxt = state_of(cnt_nxt);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cnt       <= '0;
      state     <= ST_IDLE;
      commit_ok <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_valid <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      state     <= state_nxt;
      commit_ok <= accept;
      if (accept)            cfg_valid <= 1'b1;
      if (commit && !accept) cfg_err   <= 1'b1;
    end
  end

  generate
    if (SHADOW) begin : g_shadow
      logic [NUM_BITS-1:0] shadow;
      always_ff @(posedge prog_clk) begin
        if (prog_reset)  shadow <= '0;
        else if (accept) shadow <= sr;
      end
      assign mem_out = shadow;
    end else begin : g_direct
      assign mem_out = sr;
    end
  endgenerate

  assign mem_outb = ~mem_out;

endmodule
